// File: rtl/fixed_adder_tree_arb_pkg.sv
// Shared constants and helpers for the fixed adder tree arbiter.
// Latency: n/a; backpressure: n/a.
package fixed_adder_tree_arb_pkg;

  localparam int DEFAULT_MAX_OUTSTANDING = 8;

  // ID width that stays at least 1 bit when only one requester exists
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fixed_adder_tree_arb_tag_fifo.sv
// In-order requester-ID FIFO tracking which requester owns each result in the tree.
// Latency: head visible the cycle after push; push ignored when full, pop ignored when empty.
module fixed_adder_tree_arb_tag_fifo #(
  parameter int ID_WIDTH = 2,
  parameter int DEPTH    = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [ID_WIDTH-1:0] push_id,
  input  logic                pop,
  output logic [ID_WIDTH-1:0] head_id,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  logic [ID_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/fixed_adder_tree_arbiter.sv
// Shares one fixed adder tree among NUM_REQ requesters; results routed back by an in-order tag FIFO.
// Zero latency both ways; issue stalls when the tag FIFO is full; FIXED_ADDER_TREE_ARB_FIXED_PRIO_EN selects strict priority.
module fixed_adder_tree_arbiter
  import fixed_adder_tree_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int IN_SIZE         = 4,
  parameter int IN_WIDTH        = 32,
  parameter int OUT_WIDTH       = $clog2(IN_SIZE) + IN_WIDTH,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ID_WIDTH        = clog2_min1(NUM_REQ),
  localparam int VEC_W          = IN_SIZE * IN_WIDTH,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*VEC_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [VEC_W-1:0]           tree_data_in,
  output logic                       tree_in_valid,
  input  logic                       tree_in_ready,
  input  logic [OUT_WIDTH-1:0]       tree_data_out,
  input  logic                       tree_out_valid,
  output logic                       tree_out_ready,
  output logic [OUT_WIDTH-1:0]       rsp_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [CNT_W-1:0]           outstanding,
  output logic                       busy
);

  logic [ID_WIDTH-1:0] gnt;
  logic [ID_WIDTH-1:0] head_id;
  logic                fifo_full;
  logic                fifo_empty;
  logic                can_issue;
  logic                issue_fire;
  logic                ret_fire;

`ifdef FIXED_ADDER_TREE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) gnt = ID_WIDTH'(i);
    end
  end
`else
  logic [ID_WIDTH-1:0] rr_ptr;

  // Scan the rotation backwards so the closest valid requester to rr_ptr wins
  always_comb begin
    int idx;
    idx = 0;
    gnt = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req_valid[idx]) gnt = ID_WIDTH'(idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue_fire) begin
      rr_ptr <= (gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end
`endif

  // Full blocks issue even when a pop lands the same cycle, keeping ready off the valid path
  assign can_issue     = (|req_valid) && !fifo_full;
  assign tree_in_valid = can_issue;
  assign issue_fire    = can_issue && tree_in_ready;
  assign tree_data_in  = req_data[int'(gnt)*VEC_W +: VEC_W];

  assign tree_out_ready = !fifo_empty && rsp_ready[head_id];
  assign ret_fire       = tree_out_valid && tree_out_ready;
  assign rsp_data       = tree_data_out;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_ready[r] = issue_fire && (gnt == ID_WIDTH'(r));
      rsp_valid[r] = tree_out_valid && !fifo_empty && (head_id == ID_WIDTH'(r));
    end
  end

  fixed_adder_tree_arb_tag_fifo #(
    .ID_WIDTH (ID_WIDTH),
    .DEPTH    (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (issue_fire),
    .push_id (gnt),
    .pop     (ret_fire),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

  assign busy = (outstanding != '0);

endmodule

// File: tb/tb_fixed_adder_tree_arbiter.sv
// Bench for fixed_adder_tree_arbiter: table-driven grant checks plus a tree model and result scoreboard.
module tb_fixed_adder_tree_arbiter;

  localparam int NR = 4;
  localparam int IS = 4;
  localparam int IW = 32;
  localparam int OW = 34;
  localparam int VW = IS * IW;
  localparam int CW = 4;

`ifdef FIXED_ADDER_TREE_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*VW-1:0]  req_data;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [VW-1:0]     tree_data_in;
  logic              tree_in_valid;
  logic              tree_in_ready;
  logic [OW-1:0]     tree_data_out;
  logic              tree_out_valid;
  logic              tree_out_ready;
  logic [OW-1:0]     rsp_data;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [CW-1:0]     outstanding;
  logic              busy;

  typedef struct {
    logic [3:0] vld;
    logic       tir;
    logic [3:0] rdy_rr;
    logic [3:0] rdy_fp;
    logic       tiv;
  } row_t;

  typedef struct {
    int            id;
    logic [OW-1:0] sum;
  } exp_t;

  exp_t          exp_q[$];
  logic [OW-1:0] tree_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          tree_en;
  logic          q_nonempty;
  logic [OW-1:0] q_head;

  assign tree_out_valid = tree_en && q_nonempty;
  assign tree_data_out  = q_head;

  always #5 clk = ~clk;

  fixed_adder_tree_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .tree_data_in   (tree_data_in),
    .tree_in_valid  (tree_in_valid),
    .tree_in_ready  (tree_in_ready),
    .tree_data_out  (tree_data_out),
    .tree_out_valid (tree_out_valid),
    .tree_out_ready (tree_out_ready),
    .rsp_data       (rsp_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .outstanding    (outstanding),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] vec_sum(input int r);
    logic [OW-1:0] s;
    s = '0;
    for (int e = 0; e < IS; e++) s += OW'(req_data[(r*IS+e)*IW +: IW]);
    return s;
  endfunction

  task automatic push_exp(input logic [3:0] onehot);
    for (int r = 0; r < NR; r++)
      if (onehot[r]) exp_q.push_back('{r, vec_sum(r)});
  endtask

  task automatic set_data(input int mode);
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < IS; e++)
        req_data[(r*IS+e)*IW +: IW] = (mode == 0) ? IW'(r + 1) : IW'(r*16 + e*3 + 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) cyc();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Tree model (one-cycle pipeline, output gated by tree_en) and result scoreboard
  initial begin : tree_model
    logic          in_f;
    logic          out_f;
    logic [OW-1:0] s;
    exp_t          e;
    q_nonempty = 1'b0;
    q_head     = '0;
    forever begin
      @(negedge clk);
      in_f  = rst_n && tree_in_valid && tree_in_ready;
      out_f = rst_n && tree_out_valid && tree_out_ready;
      s = '0;
      for (int i = 0; i < IS; i++) s += OW'(tree_data_in[i*IW +: IW]);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b required none", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
          chk("rsp_data", 64'(rsp_data), 64'(e.sum));
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tree_q.delete();
      end else begin
        if (out_f) void'(tree_q.pop_front());
        if (in_f) tree_q.push_back(s);
      end
      q_nonempty = (tree_q.size() != 0);
      q_head     = q_nonempty ? tree_q[0] : '0;
    end
  end

  initial begin : main
    row_t       tbl[13];
    logic [3:0] exp_rdy;
    int         g;
    int         head;

    for (int i = 0; i < 8; i++) tbl[i] = '{4'hF, 1'b1, 4'(1 << (i % 4)), 4'b0001, 1'b1};
    tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[9]  = '{4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[10] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1};
    tbl[11] = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};

    rst_n = 1'b0; req_valid = '0; tree_in_ready = 1'b1; tree_en = 1'b0; rsp_ready = '1;
    set_data(0);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'd0);
    chk("idle_tree_in_valid", 64'(tree_in_valid), 64'd0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_tree_out_ready", 64'(tree_out_ready), 64'd0);
    chk("idle_outstanding", 64'(outstanding), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Round-robin rotation, joiners, and a stalled tree input
    tree_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      req_valid = tbl[i].vld;
      tree_in_ready = tbl[i].tir;
      #1;
      exp_rdy = FP ? tbl[i].rdy_fp : tbl[i].rdy_rr;
      chk("tbl_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("tbl_tree_in_valid", 64'(tree_in_valid), 64'(tbl[i].tiv));
      push_exp(exp_rdy);
    end
    drain("drain_tbl");
    chk("tbl_outstanding_end", 64'(outstanding), 64'd0);

    // Fill the tag FIFO with the tree output held off
    set_data(1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      tree_en = 1'b0; tree_in_ready = 1'b1; req_valid = 4'hF;
      #1;
      g = FP ? 0 : (2 + i) % 4;
      chk("fill_req_ready", 64'(req_ready), 64'(4'b0001 << g));
      push_exp(4'(1 << g));
    end
    cyc();
    #1;
    chk("full_outstanding", 64'(outstanding), 64'd8);
    chk("full_tree_in_valid", 64'(tree_in_valid), 64'd0);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    cyc();
    tree_en = 1'b1;
    #1;
    chk("full_pop_req_ready", 64'(req_ready), 64'd0);
    chk("full_pop_tree_out_ready", 64'(tree_out_ready), 64'd1);
    cyc();
    tree_en = 1'b0;
    #1;
    g = FP ? 0 : 2;
    chk("resume_req_ready", 64'(req_ready), 64'(4'b0001 << g));
    chk("resume_outstanding", 64'(outstanding), 64'd7);
    push_exp(4'(1 << g));
    cyc();
    req_valid = '0;
    #1;
    chk("refill_outstanding", 64'(outstanding), 64'd8);

    // Head-of-line stall: head requester not ready for five cycles
    head = exp_q[0].id;
    cyc();
    rsp_ready = ~(4'(1 << head));
    tree_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hol_tree_out_ready", 64'(tree_out_ready), 64'd0);
      chk("hol_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << head));
      chk("hol_outstanding", 64'(outstanding), 64'd8);
      cyc();
    end
    rsp_ready = '1;
    drain("drain_hol");
    chk("hol_outstanding_end", 64'(outstanding), 64'd0);

    // Reset with three results in flight
    for (int i = 0; i < 3; i++) begin
      cyc();
      tree_en = 1'b0; req_valid = 4'hF;
      #1;
      g = FP ? 0 : (3 + i) % 4;
      chk("pre_rst_req_ready", 64'(req_ready), 64'(4'b0001 << g));
      push_exp(4'(1 << g));
    end
    cyc();
    req_valid = '0;
    #1;
    chk("pre_rst_outstanding", 64'(outstanding), 64'd3);
    cyc();
    tree_en = 1'b1; rsp_ready = '0;
    #1;
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << exp_q[0].id));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1; tree_en = 1'b0; rsp_ready = '1;

    // Arbitration restarts from requester 0 after reset
    for (int i = 0; i < 4; i++) begin
      cyc();
      req_valid = 4'hF;
      #1;
      g = FP ? 0 : i;
      chk("post_rst_req_ready", 64'(req_ready), 64'(4'b0001 << g));
      push_exp(4'(1 << g));
    end
    cyc();
    req_valid = '0; tree_en = 1'b1;
    drain("drain_post_rst");
    chk("final_outstanding", 64'(outstanding), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_adder_tree_arbiter.md
Name: fixed_adder_tree_arbiter

Overview:
Shares one pipelined fixed adder tree between NUM_REQ independent requesters. Each requester supplies an IN_SIZE-element vector. The arbiter grants requesters round-robin, forwards the winning vector into the tree, and records the requester ID in an in-order tag FIFO. Each tree result is returned only to the requester that issued it. It sits between compute units (e.g. per-row dot-product lanes) and a single fixed_adder_tree instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
IN_SIZE, 4, elements per vector (must match the tree)
IN_WIDTH, 32, element width in bits
OUT_WIDTH, $clog2(IN_SIZE)+IN_WIDTH, tree result width
MAX_OUTSTANDING, 8, tag FIFO depth (power of 2) = max vectors in flight inside the tree
ID_WIDTH, $clog2(NUM_REQ), requester-ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_data  in  NUM_REQ*IN_SIZE*IN_WIDTH  flattened vectors; requester r at [r*IN_SIZE*IN_WIDTH +: IN_SIZE*IN_WIDTH]
req_valid  in  NUM_REQ  per-requester valid
req_ready  out  NUM_REQ  per-requester ready (one-hot or zero)
tree_data_in  out  IN_SIZE*IN_WIDTH  vector to tree
tree_in_valid  out  1  valid to tree
tree_in_ready  in  1  ready from tree
tree_data_out  in  OUT_WIDTH  tree sum
tree_out_valid  in  1  tree result valid
tree_out_ready  out  1  ready to tree
rsp_data  out  OUT_WIDTH  result, broadcast to all requesters
rsp_valid  out  NUM_REQ  one-hot result valid
rsp_ready  in  NUM_REQ  per-requester result ready
outstanding  out  $clog2(MAX_OUTSTANDING)+1  vectors in flight
busy  out  1  outstanding != 0

Behaviour:
- Reset (async on rst_n low, release synchronous to clk): rr_ptr=0, tag FIFO empty, outstanding=0, busy=0. All outputs are combinational from this state, so req_ready=0, rsp_valid=0 and tree_out_ready=0 at reset.
- Grant (combinational): g = first r with req_valid[r] set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- can_issue = |req_valid && !fifo_full. tree_in_valid = can_issue. tree_data_in = slice g.
- req_ready[g] = can_issue && tree_in_ready; all other bits are 0.
- Issue fire = tree_in_valid && tree_in_ready. On fire: push g to the tag FIFO and set rr_ptr <= (g+1) mod NUM_REQ. With no fire, rr_ptr holds.
- Grant is not locked. If tree_in_ready is low, g may change the next cycle when a higher-rotation requester raises valid. Requesters must hold valid/data until ready, per the codebase handshake rules.
- Return path (combinational): h = FIFO head.
  - rsp_valid[h] = tree_out_valid && !fifo_empty; other bits are 0.
  - tree_out_ready = !fifo_empty && rsp_ready[h].
  - rsp_data = tree_data_out.
- Return fire pops the FIFO.
- Results return strictly in issue order; a stalled head requester blocks all others (head-of-line blocking is accepted).
- Latency: zero cycles through the arbiter in both directions.
- Full: push is blocked when fifo_full, even if a pop occurs the same cycle. This removes the ready->valid comb loop.
- Empty: tree_out_valid with an empty FIFO is a protocol error. tree_out_ready stays 0 and no rsp_valid is raised.
- Simultaneous push and pop when not full: outstanding is unchanged and both pointers advance.
- outstanding += push - pop. It never exceeds MAX_OUTSTANDING.
- Reset mid-operation: FIFO contents are discarded. The tree must be reset by the same rst_n (adapted to its polarity) so no orphan results remain.

Optional Feature:
FIXED_ADDER_TREE_ARB_FIXED_PRIO_EN
- Defined: strict priority arbitration. g = lowest-index valid requester; rr_ptr is neither kept nor updated.
- Undefined: round-robin as above.
- Ports and tag behaviour are identical in both builds.

Decomposition:
- Package fixed_adder_tree_arb_pkg holds:
  - function clog2_min1(n), used for ID_WIDTH when NUM_REQ=1 in reuse;
  - localparam DEFAULT_MAX_OUTSTANDING = 8.
- Sub-module fixed_adder_tree_arb_tag_fifo: synchronous FIFO of ID_WIDTH x MAX_OUTSTANDING.
  - Ports: push, push_id, pop, head_id, full, empty, count.
  - Async active-low reset. Count-based full/empty; pointers wrap mod depth.
- Round-robin priority select stays inline as a rotate-and-find-first.

Test Plan:
1. Reset, all req_valid=0 -> req_ready=0, tree_in_valid=0, rsp_valid=0, outstanding=0, busy=0.
2. All 4 requesters valid continuously, tree_in_ready=1; vector r has all elements = r+1 -> grant order 0,1,2,3,0,...; returned sums 4,8,12,16 on rsp_valid 0001,0010,0100,1000.
3. Only requester 2 valid, then requester 1 and 3 join after 2 fires -> next grant 3 (rr_ptr=3), then 1.
4. Tree holds tree_out_valid=0 while 8 vectors issue -> outstanding=8, tree_in_valid=0 despite req_valid; one pop -> next cycle issue resumes, outstanding stays 8.
5. rsp_ready[head]=0 for 5 cycles with tree_out_valid=1 -> tree_out_ready=0, result held, later-issued requesters get no rsp_valid; release -> in-order delivery.
6. rst_n asserted with outstanding=3 -> outstanding=0 and rsp_valid=0 immediately. Rebuild with FIXED_ADDER_TREE_ARB_FIXED_PRIO_EN, all valid -> requester 0 granted every cycle.
